// File: rtl/mc_decoder.sv
// mc_decoder: multi-cycle main control FSM (IF/ID/EX/MEM/WB) for a MIPS-style core.
// Ports: clk_i, rst_n (sync, active-low), instr_op_i[5:0], mem_ready_i -> ALUOp_o[2:0],
//   datapath controls, state_o[2:0], illegal_o, instr_cnt_o[15:0].
// Optional: define MC_DECODER_JAL_EN to support jal (opcode 000011) with Link_o in WB.
module mc_decoder (
    input  logic        clk_i,
    input  logic        rst_n,
    input  logic [5:0]  instr_op_i,
    input  logic        mem_ready_i,
    output logic [2:0]  ALUOp_o,
    output logic        MemRead_o,
    output logic        MemWrite_o,
    output logic        IRWrite_o,
    output logic        PCWrite_o,
    output logic        PCSrcJump_o,
    output logic        Branch_o,
    output logic        BranchNe_o,
    output logic        ALUSrc_o,
    output logic        RegDst_o,
    output logic        MemtoReg_o,
    output logic        RegWrite_o,
    output logic        Link_o,
    output logic [2:0]  state_o,
    output logic        illegal_o,
    output logic [15:0] instr_cnt_o
);

    typedef enum logic [2:0] {
        S_IF  = 3'd0,
        S_ID  = 3'd1,
        S_EX  = 3'd2,
        S_MEM = 3'd3,
        S_WB  = 3'd4
    } state_t;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_BNE  = 6'b000101;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_JAL  = 6'b000011;

    state_t      state;
    state_t      cur;
    state_t      nxt;
    logic [5:0]  op_q;
    logic [15:0] cnt;
    logic        retire;
    logic        is_jal;

    function automatic logic is_legal(input logic [5:0] op);
        logic ok;
        ok = (op == OP_R) || (op == OP_ADDI) || (op == OP_LW) ||
             (op == OP_SW) || (op == OP_BEQ) || (op == OP_BNE) ||
             (op == OP_J);
`ifdef MC_DECODER_JAL_EN
        ok = ok || (op == OP_JAL);
`endif
        return ok;
    endfunction

`ifdef MC_DECODER_JAL_EN
    assign is_jal = (op_q == OP_JAL);
`else
    assign is_jal = 1'b0;
`endif

    // While reset is held the outputs present the IF view, whatever the
    // register still holds, so downstream logic never sees a stale command.
    assign cur         = rst_n ? state : S_IF;
    assign state_o     = cur;
    assign instr_cnt_o = cnt;

    always_comb begin
        ALUOp_o     = 3'b000;
        MemRead_o   = 1'b0;
        MemWrite_o  = 1'b0;
        IRWrite_o   = 1'b0;
        PCWrite_o   = 1'b0;
        PCSrcJump_o = 1'b0;
        Branch_o    = 1'b0;
        BranchNe_o  = 1'b0;
        ALUSrc_o    = 1'b0;
        RegDst_o    = 1'b0;
        MemtoReg_o  = 1'b0;
        RegWrite_o  = 1'b0;
        Link_o      = 1'b0;
        illegal_o   = 1'b0;
        nxt         = S_IF;
        retire      = 1'b0;

        if (cur == S_EX || cur == S_MEM || cur == S_WB) begin
            case (op_q)
                OP_R:    ALUOp_o = 3'b010;
                OP_ADDI: ALUOp_o = 3'b100;
                OP_BEQ:  ALUOp_o = 3'b001;
                OP_BNE:  ALUOp_o = 3'b110;
                default: ALUOp_o = 3'b000;
            endcase
        end

        case (cur)
            S_IF: begin
                MemRead_o = 1'b1;
                IRWrite_o = mem_ready_i;
                PCWrite_o = mem_ready_i;
                nxt       = mem_ready_i ? S_ID : S_IF;
            end
            S_ID: begin
                // Decision uses the live opcode: the register only loads at this edge.
                illegal_o = !is_legal(instr_op_i);
                nxt       = illegal_o ? S_IF : S_EX;
            end
            S_EX: begin
                ALUSrc_o    = (op_q == OP_ADDI) || (op_q == OP_LW) || (op_q == OP_SW);
                Branch_o    = (op_q == OP_BEQ) || (op_q == OP_BNE);
                BranchNe_o  = (op_q == OP_BNE);
                PCWrite_o   = (op_q == OP_J) || is_jal;
                PCSrcJump_o = (op_q == OP_J) || is_jal;
                if (op_q == OP_LW || op_q == OP_SW) begin
                    nxt = S_MEM;
                end else if (op_q == OP_R || op_q == OP_ADDI || is_jal) begin
                    nxt = S_WB;
                end else begin
                    nxt    = S_IF;
                    retire = 1'b1;
                end
            end
            S_MEM: begin
                MemRead_o  = (op_q == OP_LW);
                MemWrite_o = (op_q == OP_SW);
                if (!mem_ready_i) begin
                    nxt = S_MEM;
                end else if (op_q == OP_LW) begin
                    nxt = S_WB;
                end else begin
                    nxt    = S_IF;
                    retire = 1'b1;
                end
            end
            S_WB: begin
                RegWrite_o = 1'b1;
                RegDst_o   = (op_q == OP_R);
                MemtoReg_o = (op_q == OP_LW);
                Link_o     = is_jal;
                nxt        = S_IF;
                retire     = 1'b1;
            end
            default: nxt = S_IF;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n) begin
            state <= S_IF;
            op_q  <= 6'b000000;
            cnt   <= 16'h0000;
        end else begin
            state <= nxt;
            if (cur == S_ID) begin
                op_q <= instr_op_i;
            end
            if (retire) begin
                cnt <= cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_mc_decoder.sv
// tb_mc_decoder: directed instruction sequences with a per-instruction
// behavioural model producing the expected trace for every cycle.
module tb_mc_decoder;

    logic        clk_i = 1'b0;
    logic        rst_n = 1'b0;
    logic [5:0]  instr_op_i = 6'd0;
    logic        mem_ready_i = 1'b0;
    logic [2:0]  ALUOp_o;
    logic        MemRead_o, MemWrite_o, IRWrite_o, PCWrite_o, PCSrcJump_o;
    logic        Branch_o, BranchNe_o, ALUSrc_o, RegDst_o, MemtoReg_o;
    logic        RegWrite_o, Link_o;
    logic [2:0]  state_o;
    logic        illegal_o;
    logic [15:0] instr_cnt_o;

    mc_decoder dut (
        .clk_i(clk_i), .rst_n(rst_n), .instr_op_i(instr_op_i),
        .mem_ready_i(mem_ready_i), .ALUOp_o(ALUOp_o),
        .MemRead_o(MemRead_o), .MemWrite_o(MemWrite_o),
        .IRWrite_o(IRWrite_o), .PCWrite_o(PCWrite_o),
        .PCSrcJump_o(PCSrcJump_o), .Branch_o(Branch_o),
        .BranchNe_o(BranchNe_o), .ALUSrc_o(ALUSrc_o),
        .RegDst_o(RegDst_o), .MemtoReg_o(MemtoReg_o),
        .RegWrite_o(RegWrite_o), .Link_o(Link_o),
        .state_o(state_o), .illegal_o(illegal_o),
        .instr_cnt_o(instr_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    // control vector bit positions
    localparam logic [11:0] MR  = 12'h800;
    localparam logic [11:0] MW  = 12'h400;
    localparam logic [11:0] IRW = 12'h200;
    localparam logic [11:0] PCW = 12'h100;
    localparam logic [11:0] PJ  = 12'h080;
    localparam logic [11:0] BR  = 12'h040;
    localparam logic [11:0] BNE = 12'h020;
    localparam logic [11:0] AS  = 12'h010;
    localparam logic [11:0] RD  = 12'h008;
    localparam logic [11:0] M2R = 12'h004;
    localparam logic [11:0] RW  = 12'h002;
    localparam logic [11:0] LK  = 12'h001;

    typedef struct {
        logic        rst;
        logic [5:0]  op;
        logic        rdy;
        logic [2:0]  st;
        logic [2:0]  alu;
        logic [11:0] ctl;
        logic        ill;
        logic [15:0] cnt;
    } cyc_t;

    cyc_t        q[$];
    logic [15:0] m_cnt = 16'd0;
    int          n_chk = 0;
    int          n_fail = 0;

`ifdef MC_DECODER_JAL_EN
    localparam bit JAL_ON = 1'b1;
`else
    localparam bit JAL_ON = 1'b0;
`endif

    function automatic bit legal(input logic [5:0] op);
        case (op)
            6'b000000, 6'b001000, 6'b100011, 6'b101011,
            6'b000100, 6'b000101, 6'b000010: return 1'b1;
            6'b000011: return JAL_ON;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [2:0] alu_of(input logic [5:0] op);
        case (op)
            6'b000000: return 3'b010;
            6'b001000: return 3'b100;
            6'b000100: return 3'b001;
            6'b000101: return 3'b110;
            default:   return 3'b000;
        endcase
    endfunction

    task automatic push(input logic rst, input logic [5:0] op, input logic rdy,
                        input logic [2:0] st, input logic [2:0] alu,
                        input logic [11:0] ctl, input logic ill);
        cyc_t e;
        e.rst = rst; e.op = op; e.rdy = rdy; e.st = st;
        e.alu = alu; e.ctl = ctl; e.ill = ill; e.cnt = m_cnt;
        q.push_back(e);
    endtask

    task automatic push_reset();
        push(1'b0, 6'($urandom), 1'b1, 3'd0, 3'd0, MR | IRW | PCW, 1'b0);
        m_cnt = 16'd0;
    endtask

    // One instruction from fetch to retire (or abort by reset while in MEM).
    task automatic gen(input logic [5:0] op, input int if_wait,
                       input int mem_wait, input bit abort);
        logic [2:0]  a;
        logic [11:0] c;
        bit          is_mem, is_jal;
        a = alu_of(op);
        is_mem = (op == 6'b100011) || (op == 6'b101011);
        is_jal = JAL_ON && (op == 6'b000011);
        for (int i = 0; i < if_wait; i++)
            push(1'b1, 6'($urandom), 1'b0, 3'd0, 3'd0, MR, 1'b0);
        push(1'b1, 6'($urandom), 1'b1, 3'd0, 3'd0, MR | IRW | PCW, 1'b0);
        if (!legal(op)) begin
            push(1'b1, op, 1'($urandom), 3'd1, 3'd0, 12'h000, 1'b1);
            return;
        end
        push(1'b1, op, 1'($urandom), 3'd1, 3'd0, 12'h000, 1'b0);
        c = 12'h000;
        if (op == 6'b001000 || is_mem) c |= AS;
        if (op == 6'b000100) c |= BR;
        if (op == 6'b000101) c |= BR | BNE;
        if (op == 6'b000010 || is_jal) c |= PCW | PJ;
        push(1'b1, 6'($urandom), 1'($urandom), 3'd2, a, c, 1'b0);
        if (op == 6'b000100 || op == 6'b000101 || op == 6'b000010) begin
            m_cnt++;
            return;
        end
        if (is_mem) begin
            c = (op == 6'b100011) ? MR : MW;
            for (int i = 0; i < mem_wait; i++)
                push(1'b1, 6'($urandom), 1'b0, 3'd3, a, c, 1'b0);
            if (abort) begin
                push_reset();
                return;
            end
            push(1'b1, 6'($urandom), 1'b1, 3'd3, a, c, 1'b0);
            if (op == 6'b101011) begin
                m_cnt++;
                return;
            end
        end
        c = RW;
        if (op == 6'b000000) c |= RD;
        if (op == 6'b100011) c |= M2R;
        if (is_jal) c |= LK;
        push(1'b1, 6'($urandom), 1'($urandom), 3'd4, a, c, 1'b0);
        m_cnt++;
    endtask

    task automatic check(input string name, input logic [15:0] act,
                         input logic [15:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Single compare process: drive each modelled cycle, check at negedge.
    task automatic drain();
        cyc_t e;
        while (q.size() > 0) begin
            e = q.pop_front();
            @(posedge clk_i);
            #1;
            rst_n = e.rst;
            instr_op_i = e.op;
            mem_ready_i = e.rdy;
            @(negedge clk_i);
            check("state", 16'(state_o), 16'(e.st));
            check("aluop", 16'(ALUOp_o), 16'(e.alu));
            check("ctl", 16'({MemRead_o, MemWrite_o, IRWrite_o, PCWrite_o,
                              PCSrcJump_o, Branch_o, BranchNe_o, ALUSrc_o,
                              RegDst_o, MemtoReg_o, RegWrite_o, Link_o}),
                  16'(e.ctl));
            check("illegal", 16'(illegal_o), 16'(e.ill));
            check("cnt", instr_cnt_o, e.cnt);
        end
    endtask

    // Park one cycle in IF and pin count/state against hand values.
    task automatic idle_check(input logic [15:0] exp_cnt);
        push(1'b1, 6'($urandom), 1'b0, 3'd0, 3'd0, MR, 1'b0);
        drain();
        check("idle_state", 16'(state_o), 16'd0);
        check("idle_cnt", instr_cnt_o, exp_cnt);
    endtask

    initial begin
        push_reset();
        push_reset();
        drain();
        check("rst_cnt", instr_cnt_o, 16'd0);

        gen(6'b100011, 0, 0, 1'b0);
        check("lat_lw", 16'(q.size()), 16'd5);
        drain();
        idle_check(16'd1);

        gen(6'b000000, 0, 0, 1'b0);
        check("lat_r", 16'(q.size()), 16'd4);
        drain();
        idle_check(16'd2);

        gen(6'b101011, 1, 3, 1'b0);
        check("len_sw_wait", 16'(q.size()), 16'd8);
        drain();
        idle_check(16'd3);

        gen(6'b001000, 0, 0, 1'b0);
        check("lat_addi", 16'(q.size()), 16'd4);
        drain();
        gen(6'b000100, 0, 0, 1'b0);
        check("lat_beq", 16'(q.size()), 16'd3);
        drain();
        gen(6'b000101, 2, 0, 1'b0);
        gen(6'b000010, 0, 0, 1'b0);
        drain();
        idle_check(16'd7);

        gen(6'b111111, 0, 0, 1'b0);
        check("len_ill", 16'(q.size()), 16'd2);
        drain();
        idle_check(16'd7);

        gen(6'b000011, 0, 0, 1'b0);
`ifdef MC_DECODER_JAL_EN
        check("lat_jal", 16'(q.size()), 16'd4);
        drain();
        idle_check(16'd8);
`else
        check("len_jal_ill", 16'(q.size()), 16'd2);
        drain();
        idle_check(16'd7);
`endif

        gen(6'b100011, 2, 2, 1'b0);
        drain();
`ifdef MC_DECODER_JAL_EN
        idle_check(16'd9);
`else
        idle_check(16'd8);
`endif

        gen(6'b101011, 0, 2, 1'b1);
        drain();
        idle_check(16'd0);

        gen(6'b100011, 0, 0, 1'b0);
        drain();
        idle_check(16'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
